// File: rtl/dmem_lat.sv
// dmem_lat: multi-cycle byte-addressed data memory with valid/ready request handshake.
// Ports: clock, reset (async, active-low), req_valid/req_ready request handshake,
//   addr/data_in/write_enable/mem_byte/mem_half_word/sign_extend request fields,
//   resp_valid one-cycle response strobe with data_out (load result) and resp_err.
// Optional macro DMEM_OOR_ERR_EN: accesses running past SIZE-1 return an error
//   instead of wrapping modulo SIZE.
// Vectors use descending ranges; the big-endian MSB (bit 0 in processor numbering)
//   is bit 31 here, so the byte at addr lands in data[31:24].
module dmem_lat #(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        write_enable,
  input  logic        mem_byte,
  input  logic        mem_half_word,
  input  logic        sign_extend,
  output logic        resp_valid,
  output logic [31:0] data_out,
  output logic        resp_err
);
  localparam int AW = $clog2(SIZE);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [7:0] mem [0:SIZE-1];
  logic [CNT_W-1:0] cnt;
  logic [31:0] a_q, d_q, base, rd, ld;
  logic we_q, byte_q, half_q, sx_q, mis, err, fire;
  logic [AW-1:0] i0, i1, i2, i3;
  assign base = a_q % 32'(SIZE);
  assign i0 = AW'(base % 32'(SIZE));
  assign i1 = AW'((base + 32'd1) % 32'(SIZE));
  assign i2 = AW'((base + 32'd2) % 32'(SIZE));
  assign i3 = AW'((base + 32'd3) % 32'(SIZE));
  assign mis = half_q ? a_q[0] : (!byte_q && a_q[1:0] != 2'b00);
`ifdef DMEM_OOR_ERR_EN
  logic [32:0] last;
  assign last = {1'b0, a_q} + {31'b0, ~byte_q & ~half_q, ~byte_q};
  assign err = mis || last >= 33'(SIZE);
`else
  assign err = mis;
`endif
  assign fire = state == BUSY && cnt == '0;
  assign rd = {mem[i0], mem[i1], mem[i2], mem[i3]};
  assign ld = byte_q ? {{24{sx_q & rd[31]}}, rd[31:24]} :
              half_q ? {{16{sx_q & rd[31]}}, rd[31:16]} : rd;
  always_comb begin
    state_n    = state == IDLE ? (req_valid ? BUSY : IDLE) :
                 state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
    req_ready  = state == IDLE;
    resp_valid = state == DONE;
    resp_err   = state == DONE && err;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      d_q      <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      half_q   <= 1'b0;
      sx_q     <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        a_q    <= addr;
        d_q    <= data_in;
        we_q   <= write_enable;
        byte_q <= mem_byte;
        half_q <= !mem_byte && mem_half_word;
        sx_q   <= sign_extend;
        cnt    <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0)
        cnt <= cnt - 1'b1;
      // stores leave data_out untouched unless they fail
      if (fire && (err || !we_q))
        data_out <= err ? '0 : ld;
    end
  end
  // array has no reset so benches can preload it before releasing reset
  always_ff @(posedge clock) begin
    if (fire && we_q && !err) begin
      mem[i0] <= byte_q ? d_q[7:0] : half_q ? d_q[15:8] : d_q[31:24];
      if (!byte_q)
        mem[i1] <= half_q ? d_q[7:0] : d_q[23:16];
      if (!byte_q && !half_q) begin
        mem[i2] <= d_q[15:8];
        mem[i3] <= d_q[7:0];
      end
    end
  end
endmodule

// File: tb/tb_dmem_lat.sv
// tb_dmem_lat: randomized + directed bench for dmem_lat against a transaction-level model.
module tb_dmem_lat;
  localparam int SIZE = 16384;
  localparam int LAT  = 3;
  logic clock = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, write_enable = 1'b0, mem_byte = 1'b0, mem_half_word = 1'b0, sign_extend = 1'b0;
  logic [31:0] addr = '0, data_in = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] data_out;
  int vectors = 0, miscompares = 0;

  dmem_lat #(.SIZE(SIZE), .LATENCY(LAT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .data_in(data_in), .write_enable(write_enable), .mem_byte(mem_byte),
    .mem_half_word(mem_half_word), .sign_extend(sign_extend), .resp_valid(resp_valid),
    .data_out(data_out), .resp_err(resp_err));

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // transaction-level model: a request accepted at edge n responds at edge n+LAT,
  // and the memory is ready again from edge n+LAT+1 on
  logic [7:0] mm [SIZE];
  int n = 0, acc = -100;
  logic [31:0] ra, rdat, exp_q = '0;
  logic rwe, rb, rh, rsx, exp_ready = 1'b1, exp_valid = 1'b0, exp_err = 1'b0;

  task automatic model_access;
    int nb;
    longint b;
    logic [31:0] v;
    logic e;
`ifdef DMEM_OOR_ERR_EN
    longint lastb;
`endif
    nb = rb ? 1 : rh ? 2 : 4;
    e = (nb == 2 && ra[0]) || (nb == 4 && ra[1:0] != 2'b00);
`ifdef DMEM_OOR_ERR_EN
    lastb = longint'(ra) + nb - 1;
    if (lastb >= SIZE) e = 1'b1;
`endif
    b = longint'(ra) % SIZE;
    v = '0;
    if (!e)
      for (int k = 0; k < nb; k++)
        if (rwe) mm[int'((b + k) % SIZE)] = rdat[8*(nb-1-k) +: 8];
        else v = (v << 8) | 32'(mm[int'((b + k) % SIZE)]);
    if (!e && !rwe && nb < 4 && rsx && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
    exp_err = e;
    if (e) exp_q = '0;
    else if (!rwe) exp_q = v;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc = -100; n = 0; exp_q = '0; exp_valid = 1'b0; exp_ready = 1'b1; exp_err = 1'b0;
    end else begin
      n++;
      if (req_valid && exp_ready) begin
        acc = n; ra = addr; rdat = data_in; rwe = write_enable;
        rb = mem_byte; rh = !mem_byte && mem_half_word; rsx = sign_extend;
      end
      if (n - acc == LAT) model_access();
      exp_valid = (n - acc == LAT);
      exp_ready = (n - acc >= LAT + 1);
    end
  end

  always @(posedge clock) begin
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("resp_valid", 32'(resp_valid), 32'(exp_valid));
    check("data_out", data_out, exp_q);
    if (exp_valid) check("resp_err", 32'(resp_err), 32'(exp_err));
  end

  task automatic poke(input int a, input logic [7:0] v);
    dut.mem[a] = v;
    mm[a] = v;
  endtask

  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic we, input logic b,
                      input logic h, input logic sx, output logic [31:0] q, output logic e, output int lat);
    int k;
    @(negedge clock);
    addr = a; data_in = d; write_enable = we; mem_byte = b; mem_half_word = h; sign_extend = sx;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clock); k++; end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: req_ready stuck at %b required 1", req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0;
    addr = $urandom; data_in = $urandom; write_enable = 1'($urandom);
    mem_byte = 1'($urandom); mem_half_word = 1'($urandom); sign_extend = 1'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: resp_valid %b after %0d cycles required 1", resp_valid, lat);
    end
    q = data_out;
    e = resp_err;
  endtask

  logic [31:0] q, ra_r;
  logic e;
  int lat, accepts;

  initial begin
    for (int i = 0; i < SIZE; i++) poke(i, 8'($urandom));
    for (int i = 0; i < 4; i++) poke(32'h2000 + i, 8'h00);
    poke(32'h2004, 8'hF0); poke(32'h2005, 8'h0F);
    poke(32'h2008, 8'h11); poke(32'h2009, 8'h22); poke(32'h200A, 8'h33); poke(32'h200B, 8'h44);
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_data", data_out, 32'd0);
    reset = 1'b1;
    // reset while the DEADBEEF store is still in flight
    @(negedge clock);
    addr = 32'h2000; data_in = 32'hDEADBEEF; write_enable = 1'b1; mem_byte = 1'b0; mem_half_word = 1'b0;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(resp_valid), 32'd0);
    check("abort_data", data_out, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    xact(32'h2000, 0, 0, 0, 0, 0, q, e, lat);
    check("abort_load", q, 32'h0);
    check("abort_mem", 32'(dut.mem[32'h2000]), 32'h0);
    xact(32'h2000, 32'h12345678, 1, 0, 0, 0, q, e, lat);
    check("st_lat", 32'(lat), 32'(LAT));
    check("st_err", 32'(e), 32'd0);
    xact(32'h2000, 0, 0, 0, 0, 0, q, e, lat);
    check("ld_word", q, 32'h12345678);
    check("ld_lat", 32'(lat), 32'(LAT));
    check("mem2000", 32'(dut.mem[32'h2000]), 32'h12);
    check("mem2003", 32'(dut.mem[32'h2003]), 32'h78);
    xact(32'h2004, 0, 0, 1, 0, 1, q, e, lat);
    check("ld_byte_sx", q, 32'hFFFFFFF0);
    xact(32'h2004, 0, 0, 1, 1, 0, q, e, lat);
    check("ld_byte_zx", q, 32'h000000F0);
    xact(32'h2004, 0, 0, 0, 1, 1, q, e, lat);
    check("ld_half_sx", q, 32'hFFFFF00F);
    xact(32'h2009, 32'hAABBCCDD, 1, 1, 0, 0, q, e, lat);
    check("sb_2008", 32'(dut.mem[32'h2008]), 32'h11);
    check("sb_2009", 32'(dut.mem[32'h2009]), 32'hDD);
    check("sb_200A", 32'(dut.mem[32'h200A]), 32'h33);
    check("sb_data_hold", q, 32'hFFFFF00F);
    xact(32'h200A, 32'hAABBCCDD, 1, 0, 1, 0, q, e, lat);
    check("sh_200A", 32'(dut.mem[32'h200A]), 32'hCC);
    check("sh_200B", 32'(dut.mem[32'h200B]), 32'hDD);
    check("sh_2009", 32'(dut.mem[32'h2009]), 32'hDD);
    xact(32'h2002, 32'hCAFEF00D, 1, 0, 0, 0, q, e, lat);
    check("mis_err", 32'(e), 32'd1);
    check("mis_data", q, 32'd0);
    check("mis_lat", 32'(lat), 32'(LAT));
    check("mis_2002", 32'(dut.mem[32'h2002]), 32'h56);
    check("mis_2004", 32'(dut.mem[32'h2004]), 32'hF0);
    ra_r = 32'(SIZE) + 32'h2000;
    xact(ra_r, 0, 0, 0, 0, 0, q, e, lat);
`ifdef DMEM_OOR_ERR_EN
    check("oor_err", 32'(e), 32'd1);
    check("oor_data", q, 32'd0);
`else
    check("wrap_err", 32'(e), 32'd0);
    check("wrap_data", q, 32'h12345678);
`endif
    xact(32'(SIZE) - 2, 0, 0, 0, 0, 0, q, e, lat);
    check("edge_word_err", 32'(e), 32'd1);
    // request held continuously with fields changing every cycle
    @(negedge clock);
    accepts = 0;
    for (int i = 0; i < 5 * (LAT + 2); i++) begin
      req_valid = 1'b1;
      addr = 32'h2000 + 32'($urandom_range(0, 31)); data_in = $urandom;
      write_enable = 1'($urandom); mem_byte = 1'($urandom); mem_half_word = 1'($urandom);
      sign_extend = 1'($urandom);
      if (req_ready) accepts++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    check("held_accepts", 32'(accepts), 32'd5);
    repeat (LAT + 3) @(negedge clock);
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 3))
        0: ra_r = 32'h2000 + 32'($urandom_range(0, 63));
        1: ra_r = 32'(SIZE) - 4 + 32'($urandom_range(0, 7));
        2: ra_r = $urandom;
        default: ra_r = 32'($urandom_range(0, 15));
      endcase
      xact(ra_r, $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
           1'($urandom), q, e, lat);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
